// File: rtl/dma_copy_engine_if.sv
// dma_copy_engine_if: descriptor, status and two BRAM ports of the copy engine (master = engine, slave = register file / memories)
interface dma_copy_engine_if #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int SW = 4,
  parameter int LW = 11
);
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] length;
  logic          intr_clr;
  logic          busy;
  logic          done;
  logic          intr;
  logic          mem0_en;
  logic [SW-1:0] mem0_we;
  logic [AW-1:0] mem0_addr;
  logic [DW-1:0] mem0_wdata;
  logic [DW-1:0] mem0_rdata;
  logic          mem1_en;
  logic [SW-1:0] mem1_we;
  logic [AW-1:0] mem1_addr;
  logic [DW-1:0] mem1_wdata;
  logic [DW-1:0] mem1_rdata;
  modport master (
    input  start, src_addr, dst_addr, length, intr_clr, mem0_rdata, mem1_rdata,
    output busy, done, intr, mem0_en, mem0_we, mem0_addr, mem0_wdata,
           mem1_en, mem1_we, mem1_addr, mem1_wdata
  );
  modport slave (
    output start, src_addr, dst_addr, length, intr_clr, mem0_rdata, mem1_rdata,
    input  busy, done, intr, mem0_en, mem0_we, mem0_addr, mem0_wdata,
           mem1_en, mem1_we, mem1_addr, mem1_wdata
  );
endinterface

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: copies length words mem0[src..] -> mem1[dst..] at 1 word/cycle; ports CLK, reset, bus (descriptor in, busy/done/intr out, mem0 read port, mem1 write port)
module dma_copy_engine #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MEM_STRB_WIDTH = 4,
  parameter int LEN_WIDTH      = 11
) (
  input logic              CLK,
  input logic              reset,
  dma_copy_engine_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t                    state;
  logic [MEM_ADDR_WIDTH-1:0] src_q;
  logic [MEM_ADDR_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [LEN_WIDTH-1:0]      rd_cnt;
  logic [LEN_WIDTH-1:0]      wr_cnt;
  logic                      rd_vld;
  logic                      set_intr;
  logic                      unused_ok;
  // set_intr marks the edge that raises done; done itself also holds intr so a clear during the done cycle loses
  assign set_intr = state == DRAIN || (state == IDLE && bus.start && bus.length == '0);
  assign unused_ok = ^bus.mem1_rdata;
  assign bus.mem0_we = {MEM_STRB_WIDTH{1'b0}};
  assign bus.mem0_wdata = {MEM_DATA_WIDTH{1'b0}};
  // write stage is driven straight from the delayed read-issue flag so rdata is forwarded in the cycle it is valid
  assign bus.mem1_en = rd_vld;
  assign bus.mem1_we = {MEM_STRB_WIDTH{rd_vld}};
  assign bus.mem1_addr = rd_vld ? dst_q + MEM_ADDR_WIDTH'(wr_cnt) : '0;
  assign bus.mem1_wdata = rd_vld ? bus.mem0_rdata : '0;
  always_ff @(posedge CLK) begin
    if (reset) begin
      state         <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      rd_cnt        <= '0;
      wr_cnt        <= '0;
      rd_vld        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.intr      <= 1'b0;
      bus.mem0_en   <= 1'b0;
      bus.mem0_addr <= '0;
    end else begin
      rd_vld   <= bus.mem0_en;
      bus.intr <= set_intr | bus.done | (bus.intr & ~bus.intr_clr);
      if (rd_vld) wr_cnt <= wr_cnt + LEN_WIDTH'(1);
      case (state)
        IDLE: if (bus.start) begin
          src_q    <= bus.src_addr;
          dst_q    <= bus.dst_addr;
          len_q    <= bus.length;
          bus.busy <= 1'b1;
          if (bus.length == '0) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state         <= RUN;
            bus.mem0_en   <= 1'b1;
            bus.mem0_addr <= bus.src_addr;
            rd_cnt        <= LEN_WIDTH'(1);
          end
        end
        RUN: if (rd_cnt == len_q) begin
          state         <= DRAIN;
          bus.mem0_en   <= 1'b0;
          bus.mem0_addr <= '0;
        end else begin
          bus.mem0_addr <= src_q + MEM_ADDR_WIDTH'(rd_cnt);
          rd_cnt        <= rd_cnt + LEN_WIDTH'(1);
        end
        DRAIN: begin
          state    <= DONE;
          bus.done <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          rd_cnt   <= '0;
          wr_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: randomized copies checked against an array-level model of the transfer rules
module tb_dma_copy_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dma_copy_engine_if bus ();
  dma_copy_engine dut (.CLK(clk), .reset(rst), .bus(bus.master));
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  logic [31:0] exp1 [1024];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int done_q[$];
  int rd_q[$];
  int wr_q[$];
  int busy_n = 0;
  int busy_first = 0;
  int bad_we = 0;
  assign bus.mem1_rdata = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem0_en) bus.mem0_rdata <= mem0[bus.mem0_addr];
    if (bus.mem1_en && bus.mem1_we == 4'hF) mem1[bus.mem1_addr] <= bus.mem1_wdata;
  end
  always @(negedge clk) begin
    if (bus.done) done_q.push_back(cyc);
    if (bus.mem0_en) rd_q.push_back(int'(bus.mem0_addr));
    if (bus.mem1_en) wr_q.push_back(int'(bus.mem1_addr));
    if (bus.busy) begin
      if (busy_n == 0) busy_first = cyc;
      busy_n++;
    end
    if (bus.mem0_we != 0 || bus.mem0_wdata != 0 ||
        (bus.mem1_en ? bus.mem1_we != 4'hF : (bus.mem1_we != 0 || bus.mem1_wdata != 0))) bad_we++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic clear_mon();
    done_q.delete();
    rd_q.delete();
    wr_q.delete();
    busy_n = 0;
  endtask
  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 1024; i++) if (mem1[i] !== exp1[i]) bad++;
    check(tag, bad, 0);
  endtask
  task automatic launch(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n, output int k);
    tick();
    clear_mon();
    bus.src_addr = s;
    bus.dst_addr = d;
    bus.length = n;
    bus.start = 1'b1;
    k = cyc;
    tick();
    bus.start = 1'b0;
    bus.src_addr = 10'($urandom);
    bus.dst_addr = 10'($urandom);
    bus.length = 11'($urandom);
  endtask
  task automatic model(input logic [9:0] s, input logic [9:0] d, input int n);
    logic [9:0] a;
    logic [9:0] b;
    for (int i = 0; i < n; i++) begin
      a = 10'(s + 10'(i));
      b = 10'(d + 10'(i));
      exp1[b] = mem0[a];
    end
  endtask
  task automatic run_xfer(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n, input bit dup);
    int k;
    int lim = 0;
    int bad = 0;
    launch(s, d, n, k);
    model(s, d, int'(n));
    if (dup && n >= 3) begin
      bus.src_addr = 10'h100;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    while (done_q.size() == 0 && lim < int'(n) + 30) begin
      tick();
      lim++;
    end
    tick();
    tick();
    check("done_cnt", done_q.size(), 1);
    if (done_q.size() > 0) check("done_cyc", done_q[0], n == 0 ? k + 1 : k + int'(n) + 2);
    check("busy_first", busy_first, k + 1);
    check("busy_len", busy_n, n == 0 ? 1 : int'(n) + 2);
    check("rd_n", rd_q.size(), n);
    check("wr_n", wr_q.size(), n);
    foreach (rd_q[i]) if (rd_q[i] != int'(10'(s + 10'(i)))) bad++;
    foreach (wr_q[i]) if (wr_q[i] != int'(10'(d + 10'(i)))) bad++;
    check("addr_seq", bad, 0);
    check("intr", bus.intr, 1'b1);
    check_mem("mem1");
  endtask
  initial begin
    int k;
    bus.start = 1'b0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    bus.length = '0;
    bus.intr_clr = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = $urandom;
      mem1[i] = '0;
      exp1[i] = '0;
    end
    for (int i = 0; i < 4; i++) mem0[10'h010 + i] = 32'hA0 + 32'(i);
    tick();
    tick();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_intr", bus.intr, 1'b0);
    check("rst_en", {bus.mem0_en, bus.mem1_en, bus.mem1_we}, 0);
    check("rst_addr", {bus.mem0_addr, bus.mem1_addr}, 0);
    rst = 1'b0;
    run_xfer(10'h010, 10'h020, 11'd4, 1'b0);
    check("a_words", {mem1[10'h020], mem1[10'h021], mem1[10'h022], mem1[10'h023]},
          {32'hA0, 32'hA1, 32'hA2, 32'hA3});
    bus.intr_clr = 1'b1;
    tick();
    bus.intr_clr = 1'b0;
    check("intr_clr", bus.intr, 1'b0);
    run_xfer(10'h050, 10'h060, 11'd0, 1'b0);
    run_xfer(10'h3FE, 10'h3FF, 11'd3, 1'b0);
    run_xfer(10'h080, 10'h000, 11'd6, 1'b1);
    bus.intr_clr = 1'b1;
    tick();
    bus.intr_clr = 1'b0;
    launch(10'h200, 10'h300, 11'd2, k);
    model(10'h200, 10'h300, 2);
    while (cyc < k + 4) tick();
    check("done_at_k4", bus.done, 1'b1);
    check("intr_at_done", bus.intr, 1'b1);
    bus.intr_clr = 1'b1;
    tick();
    check("set_wins", bus.intr, 1'b1);
    tick();
    bus.intr_clr = 1'b0;
    check("clr_after", bus.intr, 1'b0);
    bus.intr_clr = 1'b1;
    tick();
    bus.intr_clr = 1'b0;
    check("clr_idle", bus.intr, 1'b0);
    launch(10'h040, 10'h140, 11'd8, k);
    model(10'h040, 10'h140, 2);
    while (cyc < k + 3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_en", {bus.mem0_en, bus.mem1_en}, 0);
    for (int i = 0; i < 12; i++) tick();
    check("mid_rst_done", done_q.size(), 0);
    check("mid_rst_wr", wr_q.size(), 2);
    check_mem("mid_rst_mem");
    run_xfer(10'h040, 10'h140, 11'd8, 1'b0);
    for (int t = 0; t < 15; t++) begin
      run_xfer(10'($urandom), 10'($urandom), 11'($urandom_range(0, 40)), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        bus.intr_clr = 1'b1;
        tick();
        bus.intr_clr = 1'b0;
        check("rand_clr", bus.intr, 1'b0);
      end
    end
    check("bus_ties", bad_we, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
